// File: rtl/spike_aer_encoder.sv
// spike_aer_encoder
//    Samples N_NEURONS spike bits every clock and turns them into address-event
//    words {timestamp, neuron_id}. Events are queued in an internal FIFO and
//    drained over a valid/ready stream, so the neuron layer is never stalled.
//    Spikes that cannot be buffered are counted (saturating) and flagged (sticky).
//
//    Ports
//       clk       in   1          clock, all state on rising edge
//       rst       in   1          asynchronous active-high reset
//       spike_in  in   N_NEURONS  spike bit per neuron
//       ev_valid  out  1          FIFO head holds an event
//       ev_ready  in   1          consumer accepts the head on valid && ready
//       ev_id     out  ID_W       neuron index of the head event
//       ev_ts     out  TS_W       timestamp of the head event
//       overflow  out  1          sticky: a spike was lost since reset
//       drop_cnt  out  DROP_W     lost spikes, saturating
//       busy      out  1          scanning, spikes pending, or FIFO not empty
module spike_aer_encoder #(
   parameter  int unsigned N_NEURONS  = 8,
   parameter  int unsigned TS_W       = 16,
   parameter  int unsigned FIFO_DEPTH = 16,
   parameter  int unsigned DROP_W     = 8,
   localparam int unsigned ID_W       = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N_NEURONS-1:0] spike_in,
   output logic                 ev_valid,
   input  logic                 ev_ready,
   output logic [ID_W-1:0]      ev_id,
   output logic [TS_W-1:0]      ev_ts,
   output logic                 overflow,
   output logic [DROP_W-1:0]    drop_cnt,
   output logic                 busy
);

   localparam int unsigned AW    = $clog2(FIFO_DEPTH);
   localparam int unsigned PTR_W = AW + 1;
   localparam int unsigned CNT_W = $clog2(N_NEURONS + 1);
   localparam int unsigned SUM_W = ((DROP_W > CNT_W) ? DROP_W : CNT_W) + 1;

   typedef enum logic [0:0] {S_IDLE, S_SCAN} state_t;

   state_t                r_state, w_state_nxt;
   logic [TS_W-1:0]       r_ts;
   logic [N_NEURONS-1:0]  r_batch, w_batch_nxt, w_batch_left;
   logic [TS_W-1:0]       r_batch_ts, w_batch_ts_nxt;
   logic [N_NEURONS-1:0]  r_next, w_next_nxt;
   logic [TS_W-1:0]       r_next_ts, w_next_ts_nxt;
   logic [N_NEURONS-1:0]  w_grant_oh;
   logic [ID_W-1:0]       w_grant_idx;
   logic [N_NEURONS-1:0]  w_coll;
   logic [CNT_W-1:0]      w_coll_cnt;
   logic [SUM_W-1:0]      w_drop_sum;
   logic [DROP_W-1:0]     r_drop_cnt;
   logic                  r_overflow;

   logic [ID_W-1:0]       r_mem_id [FIFO_DEPTH];
   logic [TS_W-1:0]       r_mem_ts [FIFO_DEPTH];
   logic [PTR_W-1:0]      r_wptr, r_rptr;
   logic [PTR_W-1:0]      w_count;
   logic [AW-1:0]         w_rd_nxt;
   logic                  w_empty, w_full, w_push, w_pop;
   logic [ID_W-1:0]       r_head_id;
   logic [TS_W-1:0]       r_head_ts;

   // ---------------- grant: lowest set bit of the batch ----------------
   assign w_grant_oh = r_batch & (~r_batch + N_NEURONS'(1));

   // Descending scan so the lowest set index is the last one written.
   always_comb begin
      w_grant_idx = '0;
      for (int unsigned i = N_NEURONS; i > 0; i--) begin
         if (r_batch[i-1]) w_grant_idx = ID_W'(i - 1);
      end
   end

   // ---------------- FIFO status ----------------
   assign w_count  = r_wptr - r_rptr;
   assign w_empty  = (r_wptr == r_rptr);
   // Full is taken from the registered pointers, i.e. before this cycle's pop.
   assign w_full   = (r_wptr[AW-1:0] == r_rptr[AW-1:0]) && (r_wptr[AW] != r_rptr[AW]);
   assign w_pop    = !w_empty && ev_ready;
   assign w_rd_nxt = r_rptr[AW-1:0] + AW'(1);

   // ---------------- FSM next state ----------------
   always_comb begin
      w_state_nxt    = r_state;
      w_batch_nxt    = r_batch;
      w_batch_ts_nxt = r_batch_ts;
      w_next_nxt     = r_next;
      w_next_ts_nxt  = r_next_ts;
      w_batch_left   = r_batch;
      w_push         = 1'b0;
      w_coll         = '0;
      unique case (r_state)
         S_IDLE: begin
            if (spike_in != '0) begin
               w_batch_nxt    = spike_in;
               w_batch_ts_nxt = r_ts;
               w_state_nxt    = S_SCAN;
            end
         end
         S_SCAN: begin
            w_push       = (r_batch != '0) && !w_full;
            w_batch_left = w_push ? (r_batch & ~w_grant_oh) : r_batch;
            // Drops are only possible against the accumulating buffer.
            w_coll       = r_next & spike_in;
            if (w_batch_left == '0) begin
               // Batch done: promote pending spikes (including this cycle's) directly.
               w_next_nxt = '0;
               if ((r_next | spike_in) != '0) begin
                  w_batch_nxt    = r_next | spike_in;
                  w_batch_ts_nxt = (r_next != '0) ? r_next_ts : r_ts;
               end else begin
                  w_batch_nxt = '0;
                  w_state_nxt = S_IDLE;
               end
            end else begin
               w_batch_nxt   = w_batch_left;
               w_next_nxt    = r_next | spike_in;
               w_next_ts_nxt = (r_next == '0) ? r_ts : r_next_ts;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // ---------------- drop counting ----------------
   always_comb begin
      w_coll_cnt = '0;
      for (int unsigned i = 0; i < N_NEURONS; i++) begin
         w_coll_cnt = w_coll_cnt + CNT_W'(w_coll[i]);
      end
   end

   assign w_drop_sum = SUM_W'(r_drop_cnt) + SUM_W'(w_coll_cnt);

   // ---------------- state registers ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_ts       <= '0;
         r_batch    <= '0;
         r_batch_ts <= '0;
         r_next     <= '0;
         r_next_ts  <= '0;
         r_drop_cnt <= '0;
         r_overflow <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_ts       <= r_ts + TS_W'(1);
         r_batch    <= w_batch_nxt;
         r_batch_ts <= w_batch_ts_nxt;
         r_next     <= w_next_nxt;
         r_next_ts  <= w_next_ts_nxt;
         if (w_coll != '0) begin
            r_overflow <= 1'b1;
            if (w_drop_sum > SUM_W'({DROP_W{1'b1}})) r_drop_cnt <= '1;
            else                                     r_drop_cnt <= DROP_W'(w_drop_sum);
         end
      end
   end

   // ---------------- FIFO storage ----------------
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem_id[r_wptr[AW-1:0]] <= w_grant_idx;
         r_mem_ts[r_wptr[AW-1:0]] <= r_batch_ts;
      end
   end

   // Head register mirrors mem[rptr]; when the FIFO is (or becomes) empty and a
   // push arrives, the pushed word is loaded directly since it is not in mem yet.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wptr    <= '0;
         r_rptr    <= '0;
         r_head_id <= '0;
         r_head_ts <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + PTR_W'(1);
         if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
         if (w_pop) begin
            if (w_count > PTR_W'(1)) begin
               r_head_id <= r_mem_id[w_rd_nxt];
               r_head_ts <= r_mem_ts[w_rd_nxt];
            end else if (w_push) begin
               r_head_id <= w_grant_idx;
               r_head_ts <= r_batch_ts;
            end
         end else if (w_empty && w_push) begin
            r_head_id <= w_grant_idx;
            r_head_ts <= r_batch_ts;
         end
      end
   end

   // ---------------- outputs ----------------
   assign ev_valid = !w_empty;
   assign ev_id    = r_head_id;
   assign ev_ts    = r_head_ts;
   assign overflow = r_overflow;
   assign drop_cnt = r_drop_cnt;
   assign busy     = (r_state == S_SCAN) || (r_next != '0) || !w_empty;

endmodule
